// File: rtl/arb2_rr_stream.sv
// arb2_rr_stream: two-input round-robin stream arbiter feeding a one-entry output register
//   clk, rst_n          : clock, asynchronous active-low reset
//   a0_valid/data/ready : source 0 handshake and payload
//   a1_valid/data/ready : source 1 handshake and payload
//   y_valid/data/ready  : registered output beat to the consumer
//   s                   : index of the source whose beat is held (mux select)
//   cnt0, cnt1          : per-source accepted-beat counters, saturating, present only with ARB2_STATS_EN
module arb2_rr_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a0_valid,
    input  logic [W-1:0] a0_data,
    output logic         a0_ready,
    input  logic         a1_valid,
    input  logic [W-1:0] a1_data,
    output logic         a1_ready,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready,
    output logic         s
`ifdef ARB2_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);
    logic can_accept, gnt, prio, acc;
    assign can_accept = !y_valid | y_ready;
    // prio only breaks ties; a lone requester always wins
    assign gnt = (a0_valid & a1_valid) ? prio : a1_valid;
    // readies are forced low while reset is held so no beat is accepted
    assign a0_ready = rst_n & can_accept & a0_valid & !gnt;
    assign a1_ready = rst_n & can_accept & a1_valid & gnt;
    assign acc = a0_ready | a1_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            s       <= 1'b0;
            prio    <= 1'b0;
        end else if (acc) begin
            y_valid <= 1'b1;
            y_data  <= gnt ? a1_data : a0_data;
            s       <= gnt;
            prio    <= ~gnt;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end
`ifdef ARB2_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (a0_ready && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (a1_ready && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif
endmodule
